// File: rtl/ghostbus_host_if.sv
`default_nettype none
//======================================================================
// Module      : ghostbus_host_if
// Description : Command, response and ghostbus port group of the
//               ghostbus host. The master modport is the host side.
// Revision    : 1.0 - initial release
//======================================================================
interface ghostbus_host_if #(
   parameter int AW = 24,
   parameter int DW = 32,
   parameter int LW = 8
);
   // Command channel
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [LW-1:0] cmd_len;
   // Response channel
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_last;
   // Ghostbus
   logic [AW-1:0] gb_addr;
   logic [DW-1:0] gb_wdata;
   logic          gb_wen;
   logic          gb_rstb;
   logic [DW-1:0] gb_rdata;
   // Status
   logic          busy;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len,
      input  rsp_ready, gb_rdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_last,
      output gb_addr, gb_wdata, gb_wen, gb_rstb, busy
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_len,
      output rsp_ready, gb_rdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_last,
      input  gb_addr, gb_wdata, gb_wen, gb_rstb, busy
   );
endinterface
`default_nettype wire

// File: rtl/ghostbus_host.sv
`default_nettype none
//======================================================================
// Module      : ghostbus_host
// Description : Ghostbus master. Turns single-beat writes and burst
//               reads from a valid/ready command channel into ghostbus
//               strobes and returns read beats on a valid/ready
//               response channel with backpressure.
// Revision    : 1.0 - initial release
//======================================================================
module ghostbus_host #(
   parameter int AW     = 24,
   parameter int DW     = 32,
   parameter int LW     = 8,
   parameter int RD_LAT = 1     // legal 1..7
) (
   input  wire              gb_clk,
   input  wire              gb_rst,
   ghostbus_host_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD_STB  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_RSP     = 3'd4
   } state_t;

   // RD_WAIT lasts RD_LAT cycles; the last one is the sample cycle.
   localparam logic [2:0]    c_WAIT_INIT = 3'(RD_LAT - 1);
   localparam logic [LW:0]   c_ONE_BEAT  = (LW+1)'(1);
   localparam logic [AW-1:0] c_ADDR_ONE  = AW'(1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic          rstb_q, rstb_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_last_q, rsp_last_d;
   logic          busy_q, busy_d;
   logic [LW:0]   beats_q, beats_d;   // LW+1 bits so a full 2^LW burst fits
   logic [2:0]    wait_q, wait_d;
   logic          w_cmd_fire;

   assign bus.cmd_ready = (state_q == S_IDLE) & ~gb_rst;
   assign w_cmd_fire    = bus.cmd_valid & bus.cmd_ready;

   assign bus.gb_addr   = addr_q;
   assign bus.gb_wdata  = wdata_q;
   assign bus.gb_wen    = wen_q;
   assign bus.gb_rstb   = rstb_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.busy      = busy_q;

   // State and output registers; reset discards any in-flight burst.
   always_ff @(posedge gb_clk or posedge gb_rst) begin
      if (gb_rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         rstb_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         beats_q     <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wen_q       <= wen_d;
         rstb_q      <= rstb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_last_q  <= rsp_last_d;
         busy_q      <= busy_d;
         beats_q     <= beats_d;
         wait_q      <= wait_d;
      end
   end

   // Next-state logic; strobes are single-cycle pulses that default low.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wen_d       = 1'b0;
      rstb_d      = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_last_d  = rsp_last_q;
      beats_d     = beats_q;
      wait_d      = wait_q;

      case (state_q)
         S_IDLE: begin
            if (w_cmd_fire) begin
               addr_d = bus.cmd_addr;
               if (bus.cmd_we) begin
                  wdata_d = bus.cmd_wdata;
                  wen_d   = 1'b1;
                  state_d = S_WR;
               end else begin
                  beats_d = {1'b0, bus.cmd_len} + c_ONE_BEAT;
                  rstb_d  = 1'b1;
                  state_d = S_RD_STB;
               end
            end
         end
         S_WR: begin
            state_d = S_IDLE;
         end
         S_RD_STB: begin
            wait_d  = c_WAIT_INIT;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Address stays put here since read muxes keep re-evaluating.
            if (wait_q == 3'd0) begin
               rsp_rdata_d = bus.gb_rdata;
               rsp_valid_d = 1'b1;
               rsp_last_d  = (beats_q == c_ONE_BEAT);
               state_d     = S_RSP;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         S_RSP: begin
            // No new bus cycle until the pending beat is consumed.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_last_d  = 1'b0;
               if (beats_q != c_ONE_BEAT) begin
                  beats_d = beats_q - c_ONE_BEAT;
                  addr_d  = addr_q + c_ADDR_ONE;
                  rstb_d  = 1'b1;
                  state_d = S_RD_STB;
               end else begin
                  beats_d = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_ghostbus_host.sv
`default_nettype none
//======================================================================
// Module      : tb_ghostbus_host
// Description : Self-checking bench for ghostbus_host. Table-driven
//               command vectors with a strobe/beat scoreboard, plus
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
//======================================================================
module tb_ghostbus_host;

   localparam int AW     = 24;
   localparam int DW     = 32;
   localparam int LW     = 8;
   localparam int RD_LAT = 1;

   logic gb_clk;
   logic gb_rst;

   ghostbus_host_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

   ghostbus_host #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
      .gb_clk (gb_clk),
      .gb_rst (gb_rst),
      .bus    (bus)
   );

   initial gb_clk = 1'b0;
   always #5 gb_clk = ~gb_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents seen through the ghostbus read mux.
   function automatic logic [31:0] mem_f(input logic [23:0] a);
      return {8'h00, a - 24'h20};
   endfunction

   // Read-data pipeline: data is only valid exactly RD_LAT cycles after a strobe.
   logic [31:0] pipe_d [RD_LAT];
   logic        pipe_v [RD_LAT];
   always @(posedge gb_clk) begin
      pipe_v[0] <= bus.gb_rstb;
      pipe_d[0] <= mem_f(bus.gb_addr);
      for (int s = 1; s < RD_LAT; s++) begin
         pipe_v[s] <= pipe_v[s-1];
         pipe_d[s] <= pipe_d[s-1];
      end
   end
   assign bus.gb_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0BAD0;

   // Scoreboard queues
   logic [55:0] wq[$];   // {addr, wdata}
   logic [23:0] sq[$];   // read strobe addresses
   logic [32:0] bq[$];   // {last, data}

   int hs_count    = 0;
   int stall_beat  = -1;
   int stall_left  = 0;
   int n_stb       = 0;

   // Response-ready driver with programmable stall on one beat.
   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(posedge gb_clk); #1;
         if (bus.rsp_valid && hs_count == stall_beat && stall_left > 0) begin
            bus.rsp_ready = 1'b0;
            stall_left--;
         end else begin
            bus.rsp_ready = 1'b1;
         end
      end
   end

   // Bus and response monitor
   logic        hs_prev = 1'b0, prev_last = 1'b0, prev_stall = 1'b0, prev_wen = 1'b0;
   logic [31:0] prev_rdata = '0;
   always @(negedge gb_clk) begin
      if (gb_rst) begin
         hs_prev = 1'b0; prev_stall = 1'b0; prev_wen = 1'b0; prev_last = 1'b0;
      end else begin
         logic hs_now;
         logic [55:0] w;
         logic [32:0] b;
         if (bus.gb_wen) begin
            check("wen_single_cycle", prev_wen, 1'b0);
            check("wen_rstb_exclusive", bus.gb_rstb, 1'b0);
            check("wr_expected", wq.size() != 0, 1'b1);
            if (wq.size() != 0) begin
               w = wq.pop_front();
               check("wr_addr", bus.gb_addr, w[55:32]);
               check("wr_data", bus.gb_wdata, w[31:0]);
            end
         end
         if (bus.gb_rstb) begin
            n_stb++;
            check("stb_expected", sq.size() != 0, 1'b1);
            if (sq.size() != 0) check("stb_addr", bus.gb_addr, sq.pop_front());
         end
         if (hs_prev) begin
            if (!prev_last) check("stb_after_handshake", bus.gb_rstb, 1'b1);
            else            check("busy_fall", bus.busy, 1'b0);
         end
         if (bus.rsp_valid) check("no_stb_while_rsp", bus.gb_rstb, 1'b0);
         if (prev_stall) begin
            check("stall_valid_held", bus.rsp_valid, 1'b1);
            check("stall_rdata_held", bus.rsp_rdata, prev_rdata);
            check("stall_last_held", bus.rsp_last, prev_last);
         end
         hs_now = bus.rsp_valid && bus.rsp_ready;
         if (hs_now) begin
            check("beat_expected", bq.size() != 0, 1'b1);
            if (bq.size() != 0) begin
               b = bq.pop_front();
               check("beat_data", bus.rsp_rdata, b[31:0]);
               check("beat_last", bus.rsp_last, b[32]);
            end
            hs_count++;
         end
         prev_stall = bus.rsp_valid && !bus.rsp_ready;
         prev_rdata = bus.rsp_rdata;
         prev_last  = bus.rsp_last;
         hs_prev    = hs_now;
         prev_wen   = bus.gb_wen;
      end
   end

   // Drive one command, queue its expected effects and wait for acceptance.
   task automatic send(input logic we, input logic [23:0] a, input logic [31:0] d, input logic [7:0] len);
      int guard;
      logic [23:0] ai;
      @(posedge gb_clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = we;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_len   = len;
      if (we) begin
         wq.push_back({a, d});
      end else begin
         for (int i = 0; i <= int'(len); i++) begin
            ai = a + 24'(i);
            sq.push_back(ai);
            bq.push_back({(i == int'(len)), mem_f(ai)});
         end
      end
      guard = 0;
      do begin
         @(negedge gb_clk);
         guard++;
      end while (!bus.cmd_ready && guard < 100);
      check("cmd_accept", bus.cmd_ready, 1'b1);
      @(posedge gb_clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 24'($urandom);
      bus.cmd_wdata = $urandom;
      bus.cmd_len   = 8'($urandom);
      check("busy_rise", bus.busy, 1'b1);
   endtask

   // Count sampled cycles with cmd_ready low after acceptance.
   task automatic wait_ready(output int cnt);
      cnt = 0;
      forever begin
         @(negedge gb_clk);
         if (bus.cmd_ready || cnt >= 5000) break;
         cnt++;
      end
   endtask

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [7:0]  len;
      int          stall_beat;
      int          stall_len;
      int          exp_cyc;     // cycles cmd_ready stays low (RD_LAT=1: 3 per beat)
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   initial begin
      int cyc;
      int base;
      int guard;

      vecs[0] = '{1'b1, 24'h000001, 32'h0000000E, 8'd0,   -1, 0, 1};
      vecs[1] = '{1'b0, 24'h000020, 32'h0,        8'd3,   -1, 0, 12};
      vecs[2] = '{1'b1, 24'hABCDEF, 32'h12345678, 8'd0,   -1, 0, 1};
      vecs[3] = '{1'b0, 24'h000020, 32'h0,        8'd3,    1, 5, 17};
      vecs[4] = '{1'b0, 24'hFFFFFF, 32'h0,        8'd1,   -1, 0, 6};
      vecs[5] = '{1'b0, 24'h000100, 32'h0,        8'd0,    0, 2, 5};
      vecs[6] = '{1'b1, 24'hFFFFFF, 32'hFFFFFFFF, 8'd0,   -1, 0, 1};
      vecs[7] = '{1'b0, 24'h000050, 32'h0,        8'd255, -1, 0, 768};
      vecs[8] = '{1'b0, 24'h000030, 32'h0,        8'd7,    7, 3, 27};

      gb_rst        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_len   = '0;

      // Reset state
      repeat (2) @(negedge gb_clk);
      check("rst_gb_addr",   bus.gb_addr,   24'h0);
      check("rst_gb_wdata",  bus.gb_wdata,  32'h0);
      check("rst_gb_wen",    bus.gb_wen,    1'b0);
      check("rst_gb_rstb",   bus.gb_rstb,   1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_last",  bus.rsp_last,  1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      @(posedge gb_clk); #1;
      gb_rst = 1'b0;
      @(negedge gb_clk);
      check("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

      // Table-driven command vectors
      for (int k = 0; k < NV; k++) begin
         hs_count   = 0;
         stall_beat = vecs[k].stall_beat;
         stall_left = vecs[k].stall_len;
         send(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].len);
         wait_ready(cyc);
         check($sformatf("vec%0d_cycles", k), cyc, vecs[k].exp_cyc);
         check($sformatf("vec%0d_idle_busy", k), bus.busy, 1'b0);
      end

      // Reset during RD_WAIT of beat 2 of a 4-beat burst
      hs_count   = 0;
      stall_beat = -1;
      stall_left = 0;
      base       = n_stb;
      send(1'b0, 24'h000040, 32'h0, 8'd3);
      guard = 0;
      while (n_stb < base + 2 && guard < 100) begin
         @(posedge gb_clk);
         guard++;
      end
      check("midrst_reached_beat2", n_stb - base, 2);
      #1;
      gb_rst = 1'b1;
      #1;
      check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      check("midrst_busy",      bus.busy,      1'b0);
      check("midrst_gb_addr",   bus.gb_addr,   24'h0);
      check("midrst_gb_rstb",   bus.gb_rstb,   1'b0);
      sq.delete();
      bq.delete();
      repeat (2) @(posedge gb_clk);
      #1;
      gb_rst = 1'b0;
      @(negedge gb_clk);
      check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge gb_clk);
         check("midrst_no_strobe", {bus.gb_rstb, bus.gb_wen, bus.rsp_valid}, 3'b000);
      end

      // Recovery: a write after reset behaves normally
      send(1'b1, 24'h123456, 32'hCAFEF00D, 8'd0);
      wait_ready(cyc);
      check("post_rst_write_cycles", cyc, 1);

      repeat (4) @(negedge gb_clk);
      check("drain_wq", wq.size(), 0);
      check("drain_sq", sq.size(), 0);
      check("drain_bq", bq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
